mem_port_arbiter: RTL and testbench

- Shares one external single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined core.
- Captures each requester's command, holds it on the memory port until the memory acknowledges, then returns read data with a one-cycle valid pulse.
- Drives per-requester stall outputs that the hazard unit ORs into stallF and the memory-stage stall.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access requesters.
// Optional macro MEM_ARB_ANTISTARVE_EN forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int INSTR_W    = 32,
    parameter int MTYPE_W    = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic [INSTR_W-1:0] if_rdata,
    output logic               if_valid,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [MTYPE_W-1:0] d_type,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_valid,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MTYPE_W-1:0] mem_type,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               stall_if,
    output logic               stall_m
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_memReq;
    logic                 r_memWe;
    logic [MTYPE_W-1:0]   r_memType;
    logic [ADDR_W-1:0]    r_memAddr;
    logic [DATA_W-1:0]    r_memWdata;
    logic [INSTR_W-1:0]   r_ifRdata;
    logic [DATA_W-1:0]    r_dRdata;
    logic                 r_ifValid;
    logic                 r_dValid;
    logic                 w_grantD;
    logic                 w_grantIf;
    logic                 w_validCycle;
    logic                 w_dFirst;

    if (STARVE_MAX < 1) begin : g_starveMaxCheck
        $error("STARVE_MAX must be at least 1");
    end

    // A requester whose valid is showing may still hold its req, so no grant is made in that cycle.
    assign w_validCycle = r_ifValid | r_dValid;

`ifdef MEM_ARB_ANTISTARVE_EN
    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starveCnt;

    assign w_dFirst = d_req & ~(if_req & (r_starveCnt >= STARVE_LIM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starveCnt <= '0;
        end else if (w_grantIf) begin
            r_starveCnt <= '0;
        end else if (w_grantD && if_req && (r_starveCnt < STARVE_LIM)) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end
`else
    assign w_dFirst = d_req;
`endif

    always_comb begin
        w_nextState = r_state;
        w_grantD    = 1'b0;
        w_grantIf   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_validCycle) begin
                    if (w_dFirst) begin
                        w_grantD    = 1'b1;
                        w_nextState = BUSY_D;
                    end else if (if_req) begin
                        w_grantIf   = 1'b1;
                        w_nextState = BUSY_IF;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    w_nextState = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Command registers change only on a grant, so they stay frozen while waiting for the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memType  <= '0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else if (w_grantD) begin
            r_memReq   <= 1'b1;
            r_memWe    <= d_we;
            r_memType  <= d_type;
            r_memAddr  <= d_addr;
            r_memWdata <= d_wdata;
        end else if (w_grantIf) begin
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b0;
            r_memType  <= '0;
            r_memAddr  <= if_addr;
        end else if (mem_ack && (r_state != IDLE)) begin
            r_memReq   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifRdata <= '0;
            r_dRdata  <= '0;
            r_ifValid <= 1'b0;
            r_dValid  <= 1'b0;
        end else begin
            r_ifValid <= 1'b0;
            r_dValid  <= 1'b0;
            if (mem_ack && (r_state == BUSY_IF)) begin
                r_ifRdata <= mem_rdata[INSTR_W-1:0];
                r_ifValid <= 1'b1;
            end
            if (mem_ack && (r_state == BUSY_D)) begin
                r_dRdata <= mem_rdata;
                r_dValid <= 1'b1;
            end
        end
    end

    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_type  = r_memType;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign if_rdata  = r_ifRdata;
    assign if_valid  = r_ifValid;
    assign d_rdata   = r_dRdata;
    assign d_valid   = r_dValid;
    assign stall_if  = if_req & ~r_ifValid;
    assign stall_m   = d_req & ~r_dValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model with programmable ack delay and
// queues of expected commands and read data; honours MEM_ARB_ANTISTARVE_EN when defined.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int INSTR_W    = 32;
    localparam int MTYPE_W    = 3;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic               we;
        logic [MTYPE_W-1:0] mtype;
        logic [DATA_W-1:0]  wdata;
    } cmd_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic [INSTR_W-1:0] if_rdata;
    logic               if_valid;
    logic               d_req;
    logic               d_we;
    logic [MTYPE_W-1:0] d_type;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic [DATA_W-1:0]  d_rdata;
    logic               d_valid;
    logic               mem_req;
    logic               mem_we;
    logic [MTYPE_W-1:0] mem_type;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ack;
    logic               stall_if;
    logic               stall_m;

    cmd_t               cmdQ[$];
    logic [INSTR_W-1:0] ifQ[$];
    logic [DATA_W-1:0]  dQ[$];
    bit                 dChkQ[$];

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   ackDelay = 0;
    bit   forceAck = 1'b0;
    int   txnCount = 0;
    int   lastReqCycles = 0;
    int   lastReqRise = 0;
    int   ifValidCount = 0;
    int   dValidCount = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W),
        .MTYPE_W(MTYPE_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    function automatic logic [DATA_W-1:0] memData(input logic [ADDR_W-1:0] a);
        if (a == 64'h1000) return 64'hCAFE_F00D_0050_0093;
        return {a[31:0] ^ 32'hA5A5_5A5A, a[31:0] + 32'h1357_9BDF};
    endfunction

    task automatic pushFetch(input logic [ADDR_W-1:0] a);
        cmd_t c;
        c.addr = a; c.we = 1'b0; c.mtype = '0; c.wdata = '0;
        cmdQ.push_back(c);
        ifQ.push_back(memData(a)[INSTR_W-1:0]);
    endtask

    task automatic pushData(input logic [ADDR_W-1:0] a, input logic we,
                            input logic [MTYPE_W-1:0] t, input logic [DATA_W-1:0] wd);
        cmd_t c;
        c.addr = a; c.we = we; c.mtype = t; c.wdata = wd;
        cmdQ.push_back(c);
        dQ.push_back(memData(a));
        dChkQ.push_back(!we);
    endtask

    // Memory model: acks ackDelay cycles after mem_req rises and checks the command it sees.
    task automatic responder();
        bit   prevReq = 1'b0;
        int   waitCnt = 0;
        int   reqCycles = 0;
        cmd_t curCmd;
        cmd_t expCmd;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!prevReq) begin
                    txnCount++;
                    lastReqRise = cycle;
                    reqCycles = 0;
                    waitCnt = 0;
                    curCmd.addr = mem_addr; curCmd.we = mem_we;
                    curCmd.mtype = mem_type; curCmd.wdata = mem_wdata;
                    checks++;
                    if (cmdQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL mem_cmd_unexpected: got transaction addr=%h, required none", mem_addr);
                    end else begin
                        expCmd = cmdQ.pop_front();
                        if (mem_addr !== expCmd.addr || mem_we !== expCmd.we || mem_type !== expCmd.mtype ||
                            (expCmd.we && mem_wdata !== expCmd.wdata)) begin
                            errors++;
                            $display("[TB] FAIL mem_cmd: got addr=%h we=%b type=%0d wdata=%h, required addr=%h we=%b type=%0d wdata=%h",
                                     mem_addr, mem_we, mem_type, mem_wdata, expCmd.addr, expCmd.we, expCmd.mtype, expCmd.wdata);
                        end
                    end
                end else begin
                    checks++;
                    if (mem_addr !== curCmd.addr || mem_we !== curCmd.we || mem_type !== curCmd.mtype ||
                        mem_wdata !== curCmd.wdata) begin
                        errors++;
                        $display("[TB] FAIL mem_cmd_stable: got addr=%h we=%b type=%0d, required addr=%h we=%b type=%0d",
                                 mem_addr, mem_we, mem_type, curCmd.addr, curCmd.we, curCmd.mtype);
                    end
                end
                reqCycles++;
                if (waitCnt == ackDelay) begin
                    mem_ack = 1'b1;
                    mem_rdata = memData(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                    waitCnt++;
                end
                prevReq = 1'b1;
            end else begin
                if (prevReq) lastReqCycles = reqCycles;
                prevReq = 1'b0;
                waitCnt = 0;
                mem_ack = forceAck;
                if (forceAck) mem_rdata = 64'hBADB_ADBA_DBAD_BADB;
            end
        end
    endtask

    task automatic scoreboardMon();
        logic [INSTR_W-1:0] eI;
        logic [DATA_W-1:0]  eD;
        bit                 chk;
        forever begin
            @(negedge clk);
            checks++;
            if (stall_if !== (if_req & ~if_valid) || stall_m !== (d_req & ~d_valid)) begin
                errors++;
                $display("[TB] FAIL stall_rel: got stall_if=%b stall_m=%b, required %b %b",
                         stall_if, stall_m, if_req & ~if_valid, d_req & ~d_valid);
            end
            if (if_valid) begin
                ifValidCount++;
                checks++;
                if (ifQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL if_valid_unexpected: got if_valid=1, required 0");
                end else begin
                    eI = ifQ.pop_front();
                    if (if_rdata !== eI) begin
                        errors++;
                        $display("[TB] FAIL if_rdata: got %h, required %h", if_rdata, eI);
                    end
                end
            end
            if (d_valid) begin
                dValidCount++;
                checks++;
                if (dQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL d_valid_unexpected: got d_valid=1, required 0");
                end else begin
                    eD = dQ.pop_front();
                    chk = dChkQ.pop_front();
                    if (chk && d_rdata !== eD) begin
                        errors++;
                        $display("[TB] FAIL d_rdata: got %h, required %h", d_rdata, eD);
                    end
                end
            end
        end
    endtask

    task automatic watchdog();
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    endtask

    task automatic waitValid(input bit isData, output bit found, output int vcyc);
        found = 1'b0;
        vcyc = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (isData ? d_valid : if_valid) begin
                found = 1'b1;
                vcyc = cycle;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b, required 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we: got %b, required 0", mem_we); end
        checks++; if (mem_type !== '0) begin errors++; $display("[TB] FAIL rst_mem_type: got %0d, required 0", mem_type); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h, required 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("[TB] FAIL rst_mem_wdata: got %h, required 0", mem_wdata); end
        checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b/%b, required 0/0", if_valid, d_valid); end
        checks++; if (if_rdata !== '0 || d_rdata !== '0) begin errors++; $display("[TB] FAIL rst_rdata: got %h/%h, required 0/0", if_rdata, d_rdata); end
        reset = 1'b1;
    endtask

    task automatic test_single_fetch();
        bit found; int vcyc; int reqCyc;
        ackDelay = 0;
        pushFetch(64'h1000);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 64'h1000; reqCyc = cycle;
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_on: got %b, required 1", stall_if); end
        waitValid(1'b0, found, vcyc);
        checks++; if (!found) begin errors++; $display("[TB] FAIL fetch_timeout: got no if_valid, required pulse"); end
        checks++; if (vcyc - reqCyc != 2) begin errors++; $display("[TB] FAIL fetch_latency: got %0d, required 2 cycles after request cycle", vcyc - reqCyc); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_off: got %b, required 0", stall_if); end
        checks++; if (lastReqCycles != 1) begin errors++; $display("[TB] FAIL fetch_req_len: got %0d, required 1", lastReqCycles); end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic test_store_late_ack();
        bit found; int vcyc; int reqCyc; int base;
        ackDelay = 2;
        base = dValidCount;
        pushData(64'h2008, 1'b1, 3'd3, 64'hDEAD_BEEF);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_type = 3'd3; d_addr = 64'h2008; d_wdata = 64'hDEAD_BEEF; reqCyc = cycle;
        waitValid(1'b1, found, vcyc);
        checks++; if (!found) begin errors++; $display("[TB] FAIL store_timeout: got no d_valid, required pulse"); end
        checks++; if (lastReqCycles != 3) begin errors++; $display("[TB] FAIL store_req_len: got %0d, required 3", lastReqCycles); end
        checks++; if (vcyc - reqCyc != 4) begin errors++; $display("[TB] FAIL store_latency: got %0d, required 4", vcyc - reqCyc); end
        @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
        @(negedge clk); #1;
        checks++; if (dValidCount - base != 1) begin errors++; $display("[TB] FAIL store_pulses: got %0d, required 1", dValidCount - base); end
    endtask

    task automatic test_load();
        bit found; int vcyc; int reqCyc;
        ackDelay = 1;
        pushData(64'h3010, 1'b0, 3'd5, 64'h0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'd5; d_addr = 64'h3010; d_wdata = 64'h1111; reqCyc = cycle;
        waitValid(1'b1, found, vcyc);
        checks++; if (!found) begin errors++; $display("[TB] FAIL load_timeout: got no d_valid, required pulse"); end
        checks++; if (vcyc - reqCyc != 3) begin errors++; $display("[TB] FAIL load_latency: got %0d, required 3", vcyc - reqCyc); end
        @(posedge clk); #1 d_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit dDone = 1'b0, iDone = 1'b0; int dV = -1, iV = -1;
        ackDelay = 0;
        pushData(64'h4000, 1'b0, 3'd2, 64'h0);
        pushFetch(64'h5000);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'd2; d_addr = 64'h4000;
        if_req = 1'b1; if_addr = 64'h5000;
        for (int i = 0; i < 60 && !(dDone && iDone); i++) begin
            @(negedge clk);
            if (d_valid && !dDone) begin dDone = 1'b1; dV = cycle; end
            if (if_valid && !iDone) begin iDone = 1'b1; iV = cycle; end
            @(posedge clk); #1;
            if (dDone) d_req = 1'b0;
            if (iDone) if_req = 1'b0;
        end
        checks++; if (!(dDone && iDone)) begin errors++; $display("[TB] FAIL simul_timeout: got done d=%b i=%b, required 1/1", dDone, iDone); end
        checks++; if (iV - dV != 3) begin errors++; $display("[TB] FAIL simul_order: got if_valid %0d cycles after d_valid, required 3", iV - dV); end
        checks++; if (lastReqRise != dV + 2) begin errors++; $display("[TB] FAIL simul_grant: got fetch mem_req at cycle %0d, required %0d", lastReqRise, dV + 2); end
    endtask

    task automatic test_back_to_back();
        bit found; int v[3];
        ackDelay = 0;
        for (int i = 0; i < 3; i++) pushData(64'hA000 + 64'(i * 16), 1'b0, 3'd3, 64'h0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'd3; d_addr = 64'hA000;
        for (int i = 0; i < 3; i++) begin
            waitValid(1'b1, found, v[i]);
            checks++; if (!found) begin errors++; $display("[TB] FAIL b2b_timeout: got no d_valid for access %0d, required pulse", i); end
            @(posedge clk); #1;
            if (i < 2) d_addr = 64'hA000 + 64'((i + 1) * 16);
            else d_req = 1'b0;
        end
        checks++; if (v[1] - v[0] != 3 || v[2] - v[1] != 3) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d,%0d, required 3,3", v[1] - v[0], v[2] - v[1]); end
    endtask

    task automatic test_spurious_ack();
        int t0, i0, d0; bit found; int vcyc; int reqCyc;
        t0 = txnCount; i0 = ifValidCount; d0 = dValidCount;
        forceAck = 1'b1;
        @(negedge clk); #1 forceAck = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ifValidCount != i0 || dValidCount != d0) begin errors++; $display("[TB] FAIL spur_valid: got %0d/%0d new pulses, required 0/0", ifValidCount - i0, dValidCount - d0); end
        checks++; if (mem_req !== 1'b0 || txnCount != t0) begin errors++; $display("[TB] FAIL spur_req: got mem_req=%b txns=%0d, required 0/0", mem_req, txnCount - t0); end
        pushFetch(64'h6000);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 64'h6000; reqCyc = cycle;
        waitValid(1'b0, found, vcyc);
        checks++; if (!found || vcyc - reqCyc != 2) begin errors++; $display("[TB] FAIL spur_followup: got found=%b latency=%0d, required 1/2", found, vcyc - reqCyc); end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic test_held_request();
        int t0, d0; bit found; int vcyc;
        ackDelay = 0;
        t0 = txnCount; d0 = dValidCount;
        pushData(64'h7000, 1'b0, 3'd3, 64'h0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'd3; d_addr = 64'h7000;
        waitValid(1'b1, found, vcyc);
        checks++; if (!found) begin errors++; $display("[TB] FAIL held_timeout: got no d_valid, required pulse"); end
        @(posedge clk); #1 d_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (txnCount - t0 != 1) begin errors++; $display("[TB] FAIL held_txns: got %0d, required 1", txnCount - t0); end
        checks++; if (dValidCount - d0 != 1) begin errors++; $display("[TB] FAIL held_pulses: got %0d, required 1", dValidCount - d0); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0; int d0; int vcyc; int reqCyc;
        ackDelay = 6;
        pushData(64'h8000, 1'b0, 3'd1, 64'h0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'd1; d_addr = 64'h8000;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL rmid_start: got mem_req=0, required 1"); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async: got mem_req=%b, required 0", mem_req); end
        dQ.delete(); dChkQ.delete();
        d_req = 1'b0;
        d0 = dValidCount;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (dValidCount != d0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_quiet: got pulses=%0d mem_req=%b, required 0/0", dValidCount - d0, mem_req); end
        reset = 1'b1;
        ackDelay = 0;
        pushFetch(64'h9000);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 64'h9000; reqCyc = cycle;
        waitValid(1'b0, found, vcyc);
        checks++; if (!found || vcyc - reqCyc != 2) begin errors++; $display("[TB] FAIL rmid_recover: got found=%b latency=%0d, required 1/2", found, vcyc - reqCyc); end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic test_starvation();
        localparam int NDATA = 5;
        int expBefore; int dCount = 0; int dBefore = -1; bit iDone = 1'b0; bit sawD, sawI;
`ifdef MEM_ARB_ANTISTARVE_EN
        expBefore = STARVE_MAX;
`else
        expBefore = NDATA;
`endif
        ackDelay = 0;
        for (int i = 0; i < NDATA; i++) begin
            if (i == expBefore) pushFetch(64'hF000);
            pushData(64'hB000 + 64'(i * 8), 1'b0, 3'd3, 64'h0);
        end
        if (expBefore >= NDATA) pushFetch(64'hF000);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_type = 3'd3; d_addr = 64'hB000;
        if_req = 1'b1; if_addr = 64'hF000;
        for (int c = 0; c < 150 && !(iDone && dCount == NDATA); c++) begin
            @(negedge clk);
            sawD = d_valid; sawI = if_valid;
            if (sawD) dCount++;
            if (sawI) begin iDone = 1'b1; dBefore = dCount; end
            @(posedge clk); #1;
            if (sawD) begin
                if (dCount < NDATA) d_addr = 64'hB000 + 64'(dCount * 8);
                else d_req = 1'b0;
            end
            if (sawI) if_req = 1'b0;
        end
        checks++; if (!iDone || dCount != NDATA) begin errors++; $display("[TB] FAIL starve_timeout: got fetch=%b data=%0d, required 1/%0d", iDone, dCount, NDATA); end
        checks++; if (dBefore != expBefore) begin errors++; $display("[TB] FAIL starve_order: got %0d data accesses before fetch, required %0d", dBefore, expBefore); end
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_type = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        fork
            responder();
            scoreboardMon();
            watchdog();
        join_none
        test_reset();
        test_single_fetch();
        test_store_late_ack();
        test_load();
        test_simultaneous();
        test_back_to_back();
        test_spurious_ack();
        test_held_request();
        test_reset_mid();
        test_starvation();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cmdQ.size() != 0 || ifQ.size() != 0 || dQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL queues_drained: got cmd=%0d if=%0d d=%0d left, required 0", cmdQ.size(), ifQ.size(), dQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
